// File: rtl/hd_cpu_pkg.sv
// Shared HD-CPU control-unit types: beat states, one-hot beat codes and
// console mode switch encodings.
package hd_cpu_pkg;

  localparam int unsigned W_WIDTH  = 3;
  localparam int unsigned SW_WIDTH = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    B1   = 2'd1,
    B2   = 2'd2,
    B3   = 2'd3
  } beat_e;

  localparam logic [W_WIDTH-1:0] W_IDLE = 3'b000;
  localparam logic [W_WIDTH-1:0] W_B1   = 3'b001;
  localparam logic [W_WIDTH-1:0] W_B2   = 3'b010;
  localparam logic [W_WIDTH-1:0] W_B3   = 3'b100;

  localparam logic [SW_WIDTH-1:0] SW_RUN       = 3'b000;
  localparam logic [SW_WIDTH-1:0] SW_WRITE_MEM = 3'b001;
  localparam logic [SW_WIDTH-1:0] SW_READ_MEM  = 3'b010;
  localparam logic [SW_WIDTH-1:0] SW_READ_REG  = 3'b011;
  localparam logic [SW_WIDTH-1:0] SW_WRITE_REG = 3'b100;

  function automatic logic [W_WIDTH-1:0] beat_to_w(input beat_e b);
    case (b)
      B1:      beat_to_w = W_B1;
      B2:      beat_to_w = W_B2;
      B3:      beat_to_w = W_B3;
      default: beat_to_w = W_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/hd_beat_sequencer.sv
// Beat sequencer for the hardwired HD-CPU control unit: drives the one-hot
// beat vector W, owns the console flag ST0 and counts completed machine cycles.
module hd_beat_sequencer
  import hd_cpu_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic                T3,
  input  logic                CLR,
  input  logic                QD,
  input  logic [SW_WIDTH-1:0] SW,
  input  logic                STEP,
  input  logic                SHORT,
  input  logic                LONG,
  input  logic                STOP,
  input  logic                SST0,
  output logic [W_WIDTH-1:0]  W,
  output logic                ST0,
  output logic                RUN,
  output logic [CNT_W-1:0]    CYC
);

  beat_e               r_state;
  logic [W_WIDTH-1:0]  r_w;
  logic                r_st0;
  logic                r_run;
  logic [CNT_W-1:0]    r_cyc;
  logic                r_qd_prev;
  logic [SW_WIDTH-1:0] r_sw_prev;

  beat_e               w_state_nxt;
  logic                w_st0_nxt;
  logic [CNT_W-1:0]    w_cyc_nxt;
  logic                w_eoc;
  logic                w_qd_rise;
  logic                w_sw_chg;

  assign w_qd_rise = QD & ~r_qd_prev;
  assign w_sw_chg  = (SW != r_sw_prev);

  // State register; W and RUN are registered from the next state.
  always_ff @(posedge T3) begin
    if (CLR) begin
      r_state   <= IDLE;
      r_w       <= W_IDLE;
      r_st0     <= 1'b0;
      r_run     <= 1'b0;
      r_cyc     <= '0;
      r_qd_prev <= QD;
      r_sw_prev <= SW;
    end else begin
      r_state   <= w_state_nxt;
      r_w       <= beat_to_w(w_state_nxt);
      r_st0     <= w_st0_nxt;
      r_run     <= (w_state_nxt != IDLE);
      r_cyc     <= w_cyc_nxt;
      r_qd_prev <= QD;
      r_sw_prev <= SW;
    end
  end

  // Next-state: SW change beats everything, then cycle end/advance, then start.
  always_comb begin
    w_state_nxt = r_state;
    w_st0_nxt   = r_st0;
    w_cyc_nxt   = r_cyc;
    w_eoc       = 1'b0;
    if (w_sw_chg) begin
      w_state_nxt = IDLE;
      w_st0_nxt   = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_qd_rise) begin
            w_state_nxt = B1;
            w_cyc_nxt   = '0;
          end
        end
        B1: begin
          if (SHORT) w_eoc = 1'b1;
          else       w_state_nxt = B2;
        end
        B2: begin
          if (!LONG) w_eoc = 1'b1;
          else       w_state_nxt = B3;
        end
        B3:      w_eoc = 1'b1;
        default: w_state_nxt = IDLE;
      endcase
      if (w_eoc) begin
        w_state_nxt = (STOP || STEP) ? IDLE : B1;
        if (SST0) w_st0_nxt = 1'b1;
        if (r_cyc != {CNT_W{1'b1}}) w_cyc_nxt = r_cyc + CNT_W'(1);
      end
    end
  end

  assign W   = r_w;
  assign ST0 = r_st0;
  assign RUN = r_run;
  assign CYC = r_cyc;

endmodule

// File: tb/tb_hd_beat_sequencer.sv
// Self-checking bench: two sequencer instances (8-bit and 2-bit counter) run
// directed scenarios and random stimulus against a beat-number reference model.
module tb_hd_beat_sequencer;

  logic       T3 = 1'b0;
  logic       CLR, QD, STEP, SHORT, LONG, STOP, SST0;
  logic [2:0] SW;

  logic [2:0] w8, w2;
  logic       st0_8, st0_2, run8, run2;
  logic [7:0] cyc8;
  logic [1:0] cyc2;

  int n_checks = 0;
  int n_fail   = 0;

  hd_beat_sequencer #(.CNT_W(8)) u_dut8 (
    .T3(T3), .CLR(CLR), .QD(QD), .SW(SW), .STEP(STEP), .SHORT(SHORT),
    .LONG(LONG), .STOP(STOP), .SST0(SST0),
    .W(w8), .ST0(st0_8), .RUN(run8), .CYC(cyc8)
  );

  hd_beat_sequencer #(.CNT_W(2)) u_dut2 (
    .T3(T3), .CLR(CLR), .QD(QD), .SW(SW), .STEP(STEP), .SHORT(SHORT),
    .LONG(LONG), .STOP(STOP), .SST0(SST0),
    .W(w2), .ST0(st0_2), .RUN(run2), .CYC(cyc2)
  );

  always #5 T3 = ~T3;

  // Reference model: beat number 0 (idle) or 1..3, counts as plain integers.
  int   m_beat = 0;
  int   m_cyc8 = 0;
  int   m_cyc2 = 0;
  logic m_st0  = 1'b0;
  logic m_qd_prev = 1'b0;
  logic [2:0] m_sw_prev = 3'b000;

  always @(posedge T3) begin
    bit cycle_done;
    if (CLR) begin
      m_beat = 0; m_st0 = 1'b0; m_cyc8 = 0; m_cyc2 = 0;
    end else if (SW != m_sw_prev) begin
      m_beat = 0; m_st0 = 1'b0;
    end else if (m_beat == 0) begin
      if (QD && !m_qd_prev) begin
        m_beat = 1; m_cyc8 = 0; m_cyc2 = 0;
      end
    end else begin
      cycle_done = (m_beat == 3) || (m_beat == 1 && SHORT) || (m_beat == 2 && !LONG);
      if (cycle_done) begin
        if (m_cyc8 < 255) m_cyc8 = m_cyc8 + 1;
        if (m_cyc2 < 3)   m_cyc2 = m_cyc2 + 1;
        if (SST0) m_st0 = 1'b1;
        m_beat = (STOP || STEP) ? 0 : 1;
      end else begin
        m_beat = m_beat + 1;
      end
    end
    m_qd_prev = QD;
    m_sw_prev = SW;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_model();
    logic [2:0] ew;
    ew = (m_beat == 0) ? 3'b000 : 3'(1 << (m_beat - 1));
    chk("W8",    32'(w8),    32'(ew));
    chk("ST0_8", 32'(st0_8), 32'(m_st0));
    chk("RUN8",  32'(run8),  32'(m_beat != 0));
    chk("CYC8",  32'(cyc8),  32'(m_cyc8));
    chk("W2",    32'(w2),    32'(ew));
    chk("ST0_2", 32'(st0_2), 32'(m_st0));
    chk("RUN2",  32'(run2),  32'(m_beat != 0));
    chk("CYC2",  32'(cyc2),  32'(m_cyc2));
  endtask

  task automatic tick();
    @(posedge T3);
    #1;
    compare_model();
  endtask

  initial begin
    CLR = 1'b1; QD = 1'b0; SW = 3'b000; STEP = 1'b0;
    SHORT = 1'b0; LONG = 1'b0; STOP = 1'b0; SST0 = 1'b0;
    tick();
    CLR = 1'b0;
    chk("rst_W", 32'(w8), 32'h0);
    chk("rst_CYC", 32'(cyc8), 32'h0);

    // Short cycle with STOP in B1
    QD = 1'b1; SHORT = 1'b1; STOP = 1'b1;
    tick(); chk("s1_W_b1", 32'(w8), 32'h1);
    tick(); chk("s1_W_end", 32'(w8), 32'h0);
    chk("s1_CYC", 32'(cyc8), 32'h1);
    chk("s1_RUN", 32'(run8), 32'h0);
    chk("s1_ST0", 32'(st0_8), 32'h0);

    // Three two-beat cycles, STOP in the last B2
    QD = 1'b0; SHORT = 1'b0; STOP = 1'b0;
    tick();
    QD = 1'b1;
    tick(); chk("s2_W_b1", 32'(w8), 32'h1);
    repeat (5) tick();
    chk("s2_W_b2", 32'(w8), 32'h2);
    STOP = 1'b1;
    tick(); chk("s2_W_end", 32'(w8), 32'h0);
    chk("s2_CYC", 32'(cyc8), 32'h3);

    // LONG in B2 reaches B3; LONG only in B1 does not
    STOP = 1'b0; QD = 1'b0;
    tick();
    QD = 1'b1; LONG = 1'b1;
    tick(); tick(); tick();
    chk("s3_W_b3", 32'(w8), 32'h4);
    STOP = 1'b1;
    tick(); chk("s3_W_end", 32'(w8), 32'h0);
    STOP = 1'b0; QD = 1'b0; LONG = 1'b0;
    tick();
    QD = 1'b1;
    tick();
    LONG = 1'b1;
    tick();
    LONG = 1'b0; STOP = 1'b1;
    tick(); chk("s3_noB3", 32'(w8), 32'h0);

    // ST0 set by SST0, kept across restart, cleared by SW change
    STOP = 1'b0; QD = 1'b0; SW = 3'b001;
    tick();
    tick();
    QD = 1'b1; SHORT = 1'b1; SST0 = 1'b1; STOP = 1'b1;
    tick(); tick();
    chk("s4_ST0_set", 32'(st0_8), 32'h1);
    SST0 = 1'b0; QD = 1'b0;
    tick();
    QD = 1'b1;
    tick();
    chk("s4_ST0_keep", 32'(st0_8), 32'h1);
    chk("s4_W_b1", 32'(w8), 32'h1);
    SW = 3'b010;
    tick();
    chk("s4_sw_W", 32'(w8), 32'h0);
    chk("s4_sw_ST0", 32'(st0_8), 32'h0);

    // Single-step halts after each cycle; held QD does not restart
    SHORT = 1'b0; STOP = 1'b0; STEP = 1'b1; QD = 1'b0;
    tick();
    QD = 1'b1;
    tick(); tick(); tick();
    chk("s5_halt", 32'(w8), 32'h0);
    repeat (2) tick();
    chk("s5_qd_hold", 32'(run8), 32'h0);
    QD = 1'b0;
    tick();
    QD = 1'b1;
    tick(); chk("s5_restart_CYC", 32'(cyc8), 32'h0);
    tick(); tick();
    chk("s5_CYC", 32'(cyc8), 32'h1);

    // Counter saturation and CLR mid-B2
    STEP = 1'b0; SHORT = 1'b1; QD = 1'b0;
    tick();
    QD = 1'b1;
    tick();
    repeat (5) tick();
    chk("s6_sat2", 32'(cyc2), 32'h3);
    chk("s6_cnt8", 32'(cyc8), 32'h5);
    SHORT = 1'b0;
    tick();
    chk("s6_W_b2", 32'(w8), 32'h2);
    CLR = 1'b1;
    tick();
    chk("s6_clr_W", 32'(w8), 32'h0);
    chk("s6_clr_CYC", 32'(cyc8), 32'h0);
    CLR = 1'b0;

    // Random stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      CLR   = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 39) == 0) SW = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) QD = ~QD;
      SHORT = ($urandom_range(0, 2) == 0);
      LONG  = ($urandom_range(0, 1) == 0);
      STOP  = ($urandom_range(0, 5) == 0);
      STEP  = ($urandom_range(0, 9) == 0);
      SST0  = ($urandom_range(0, 4) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hd_beat_sequencer.md
Name: hd_beat_sequencer

Overview:
Beat/timing sequencer for the hardwired HD-CPU control unit. It produces the one-hot beat vector W[3:1] that the combinational decoder consumes, and owns the console state flag ST0. It honours the decoder's SHORT/LONG/STOP requests and the SST0 set-request, so multi-beat and multi-cycle console and instruction operations proceed under one clock. It sits between the front-panel start (QD) and switches and the decoder.

Parameters:
CNT_W, 8, width of the completed-machine-cycle counter CYC (saturating)

Ports:
T3  in  1  system clock; all state updates on rising edge
CLR  in  1  synchronous active-high reset
QD  in  1  start request from front panel, level; rising edge detected internally
SW  in  3  console mode switches; any change aborts and clears ST0
STEP  in  1  single-step: stop after every machine cycle
SHORT  in  1  decoder: current machine cycle ends after W1
LONG  in  1  decoder: current machine cycle extends to W3
STOP  in  1  decoder: halt at end of current machine cycle
SST0  in  1  decoder: set ST0 at end of current machine cycle
W  out  3  one-hot beat vector, W[1]/W[2]/W[3]; 000 when idle
ST0  out  1  console second-phase flag
RUN  out  1  sequencer active (W != 000)
CYC  out  CNT_W  count of completed machine cycles since reset/start, saturating

Behaviour:
- Reset (CLR=1 at edge): W=000, ST0=0, RUN=0, CYC=0, state IDLE, internal QD/SW history registers loaded with the current QD/SW values (no spurious edge after reset).
- States: IDLE, B1, B2, B3. W is registered and one-hot: B1->001, B2->010, B3->100, IDLE->000. RUN = (state != IDLE).
- IDLE: QD rising edge (QD=1, previous QD=0) -> B1 next cycle; CYC cleared to 0 on this start. QD level held high does not retrigger.
- End-of-machine-cycle (EOC) occurs in B1 if SHORT=1, in B2 if SHORT=0 and LONG=0, and in B3 always. Otherwise B1->B2 and B2->B3.
- SHORT and LONG both 1 in B1: SHORT wins. LONG is sampled in B2 only. SHORT is sampled in B1 only.
- At EOC: if STOP=1 or STEP=1 -> IDLE, else -> B1. If SST0=1 -> ST0<=1. CYC increments by 1 and saturates at all-ones.
- SST0, STOP and STEP outside EOC are ignored. STOP never truncates a cycle mid-way.
- ST0 clears only on reset or an SW change. It is never cleared by STOP or EOC.
- SW change (SW != registered previous SW): state->IDLE, W=000, ST0=0 on the next edge. This takes priority over EOC, SST0 and QD in the same cycle. CYC holds its value.
- QD edges while RUN=1 are ignored.
- Priority, high to low: CLR, SW change, EOC/beat advance, QD start.
- Latency: QD edge sampled at edge n gives W=001 after edge n. Beats advance every T3 edge with no wait states.

Decomposition:
- Shared package hd_cpu_pkg:
  - beat state enum (IDLE, B1, B2, B3)
  - one-hot W constants W_IDLE=3'b000, W_B1=3'b001, W_B2=3'b010, W_B3=3'b100
  - SW mode constants (000 run, 001 write mem, 010 read mem, 011 read reg, 100 write reg)
- Single module. The saturating counter is inline; no sub-module is warranted.

Test Plan:
- Reset then QD 0->1, SHORT=1, STOP=1 in B1 -> W: 000,001,000. ST0=0, CYC=1, RUN low after 2 edges.
- QD pulse, SHORT=0, LONG=0, STOP=0 for 2 cycles, then STOP=1 in B2 -> W sequence 001,010,001,010,001,010,000. CYC=3.
- LONG=1 in B2, STOP=1 in B3 -> W: 001,010,100,000. LONG asserted in B1 alone does not produce B3.
- SW=001, SHORT=1, SST0=1, STOP=1 in B1 -> after the cycle ST0=1. Second QD -> ST0 stays 1. SW changed to 010 mid-B1 -> next edge W=000, ST0=0.
- STEP=1, STOP=0, normal two-beat cycle -> halts after B2 (W=000). QD held high does not restart; QD low then high restarts with CYC=1 after the cycle.
- CNT_W=2, 5 consecutive cycles without STOP -> CYC saturates at 3. CLR asserted mid-B2 -> next edge all outputs 0.
